// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial, LSB-first two's-complement subtractor. Computes A - B one bit
//   per clock through a single full-subtractor cell and a borrow flop, with a
//   Start/Ready/Done handshake.
//
//   Optional feature macro: SERIAL_SUB_OVF_EN adds the Overflow port and the
//   sign latches that feed it.
//
// Handshake: Start is a request that is accepted only on an edge where Ready=1
//   (state IDLE). Start while Busy or Done is dropped, never queued. Done is a
//   one-cycle pulse; Diff/Borrow (and Overflow) are valid from that pulse and
//   hold until the next result is loaded.
//
// Ports:
//   Clk       rising-edge clock
//   Rst       synchronous active-high reset
//   Start     operation request
//   A, B      minuend / subtrahend, sampled on the accepting edge
//   Ready     high in IDLE
//   Busy      high in RUN
//   Done      one-cycle result-valid pulse
//   Diff      A - B mod 2^WIDTH, registered
//   Borrow    unsigned borrow-out (A < B), registered
//   Overflow  signed overflow (SERIAL_SUB_OVF_EN only)
//   dbg_state current FSM state encoding (0 IDLE, 1 RUN, 2 DONE)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
`ifdef SERIAL_SUB_OVF_EN
  output logic             Overflow,
`endif
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs.
  logic a_bit, b_bit, d_bit, br_nxt;

  always_comb begin
    a_bit  = a_sr_q[0];
    b_bit  = b_sr_q[0];
    d_bit  = a_bit ^ b_bit ^ br_q;
    br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  end

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    diff_d    = diff_q;
    br_d      = br_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
    sa_d      = sa_q;
    sb_d      = sb_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          a_sr_d  = A;
          b_sr_d  = B;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          sa_d    = A[WIDTH-1];
          sb_d    = B[WIDTH-1];
`endif
        end
      end
      ST_RUN: begin
        a_sr_d    = a_sr_q >> 1;
        b_sr_d    = b_sr_q >> 1;
        diff_sr_d = {d_bit, diff_sr_q[WIDTH-1:1]};
        br_d      = br_nxt;
        cnt_d     = cnt_q + CW'(1);
        // Last bit: publish the result on the same edge that shifts it in,
        // so Diff never shows partial values during RUN.
        if (cnt_q == LAST_BIT) begin
          state_d  = ST_DONE;
          diff_d   = {d_bit, diff_sr_q[WIDTH-1:1]};
          borrow_d = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
          // Overflow only when operand signs differ and the result sign
          // disagrees with the minuend.
          ovf_d    = (sa_q != sb_q) && (d_bit != sa_q);
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      diff_q    <= '0;
      br_q      <= 1'b0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
`ifdef SERIAL_SUB_OVF_EN
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      diff_q    <= diff_d;
      br_q      <= br_d;
      borrow_q  <= borrow_d;
      cnt_q     <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  always_comb begin
    Ready     = (state_q == ST_IDLE);
    Busy      = (state_q == ST_RUN);
    Done      = (state_q == ST_DONE);
    Diff      = diff_q;
    Borrow    = borrow_q;
    dbg_state = state_q;
`ifdef SERIAL_SUB_OVF_EN
    Overflow  = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             overflow;
`endif
  logic [1:0]       dbg_state;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .Clk       (clk),
    .Rst       (rst),
    .Start     (start),
    .A         (a),
    .B         (b),
    .Ready     (ready),
    .Busy      (busy),
    .Done      (done),
    .Diff      (diff),
    .Borrow    (borrow),
`ifdef SERIAL_SUB_OVF_EN
    .Overflow  (overflow),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [WIDTH:0] exp_q[$];     // {borrow, diff}
  logic           exp_ovf_q[$];
  int             exp_cyc_q[$]; // cycle stamp at which Done must be seen

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every Done must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        logic [WIDTH:0] e;
        logic           eo;
        int             ec;
        e  = exp_q.pop_front();
        eo = exp_ovf_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("diff", {24'd0, diff}, {24'd0, e[WIDTH-1:0]});
        check("borrow", {31'd0, borrow}, {31'd0, e[WIDTH]});
        check("done_latency", cyc, ec);
`ifdef SERIAL_SUB_OVF_EN
        check("overflow", {31'd0, overflow}, {31'd0, eo});
`else
        if (eo === 1'bx) check("ovf_model", 32'd0, 32'd1);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] r;
    r = {1'b0, x} - {1'b0, y};
    return r; // r[WIDTH] is the unsigned borrow
  endfunction

  task automatic push_exp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] r;
    r = model(x, y);
    exp_q.push_back(r);
    exp_ovf_q.push_back((x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]));
    // Accept at the next posedge (E0); Done visible after E0+WIDTH.
    exp_cyc_q.push_back(cyc + 1 + WIDTH);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    wait_ready();
    start = 1'b1;
    a = x;
    b = y;
    push_exp(x, y);
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    exp_q.delete();
    exp_ovf_q.delete();
    exp_cyc_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int accepts;
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    apply_reset();

    // Reset state.
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_borrow", {31'd0, borrow}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", {31'd0, overflow}, 32'd0);
`endif

    // 5 - 3 with cycle-by-cycle status checks.
    do_op(8'd5, 8'd3);
    for (int i = 0; i < WIDTH; i++) begin
      check("busy_run", {31'd0, busy}, 32'd1);
      check("ready_run", {31'd0, ready}, 32'd0);
      check("diff_hold_run", {24'd0, diff}, 32'd0);
      @(negedge clk);
    end
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("ready_after_done", {31'd0, ready}, 32'd1);
    check("diff_hold", {24'd0, diff}, 32'h02);

    // Back-to-back: second Done must come WIDTH+2 cycles after the first.
    do_op(8'd3, 8'd5);
    do_op(8'hFF, 8'hFF);
    drain();
    check("b2b_spacing", last_done_cyc - prev_done_cyc, WIDTH + 2);

    // Start held high: one accept per Ready window, no extra Done.
    wait_ready();
    accepts = 0;
    d0 = done_cnt;
    a = 8'h00;
    b = 8'h01;
    start = 1'b1;
    for (int i = 0; i < 3 * (WIDTH + 2) - 1; i++) begin
      if (ready) begin
        push_exp(8'h00, 8'h01);
        accepts++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    drain();
    check("held_accepts", accepts, 3);
    check("held_dones", done_cnt - d0, 3);

    // Reset mid-RUN at E4 aborts without Done.
    do_op(8'h10, 8'h01);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_ovf_q.delete();
    exp_cyc_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_diff", {24'd0, diff}, 32'd0);
    check("abort_borrow", {31'd0, borrow}, 32'd0);
    rst = 1'b0;
    repeat (2 * WIDTH) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    do_op(8'h10, 8'h01);
    drain();
    check("after_abort_diff", {24'd0, diff}, 32'h0F);

    // Signed-overflow boundary cases (Diff/Borrow always checked).
    do_op(8'h80, 8'h01);
    do_op(8'h7F, 8'hFF);
    do_op(8'h05, 8'h03);
    do_op(8'h00, 8'h00);
    do_op(8'hFF, 8'h00);
    drain();

    // Randomised operand pairs.
    for (int i = 0; i < 1000; i++) begin
      do_op(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)));
    end
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, LSB-first two's-complement subtractor computing A − B one bit per clock through a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the combinational half/full adder datapath: same operand naming, serialised for area, with a start/done handshake. The block is used as a shared arithmetic unit behind a simple controller, where latency is traded for gate count.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only while Ready=1
- A  input  WIDTH  minuend; sampled on the accepting edge
- B  input  WIDTH  subtrahend; sampled on the accepting edge
- Ready  output  1  high in IDLE; a new Start is accepted
- Busy  output  1  high in RUN
- Done  output  1  one-cycle pulse when the result is valid
- Diff  output  WIDTH  result A − B mod 2^WIDTH, registered
- Borrow  output  1  unsigned borrow-out (1 when A < B unsigned), registered
- Overflow  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN

## Operation
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from the state register.
- IDLE → RUN on an edge where Start=1. Load a_sr=A, b_sr=B, clear the borrow flop br=0 and the bit counter cnt=0. Start while Busy or Done is ignored, with no queueing.
- Each RUN edge processes a=a_sr[0], b=b_sr[0]:
  - d = a^b^br
  - br_next = (~a&b) | (~(a^b)&br)
  - shift a_sr and b_sr right
  - diff_sr = {d, diff_sr[WIDTH-1:1]}
  - cnt++
- RUN → DONE on the edge where cnt==WIDTH-1, which processes the last bit. On that edge, Diff is loaded with the final shifted value and Borrow with br_next.
- DONE → IDLE on the next edge, unconditionally.
- Diff and Borrow hold their value from Done until the next result is loaded. They do not change during RUN.
- Ready = (state==IDLE), Busy = (state==RUN), Done = (state==DONE).
- Reset values: state=IDLE, Ready=1, Busy=0, Done=0, Diff=0, Borrow=0, Overflow=0, all internal shift registers, br and cnt = 0.
- Reset mid-RUN aborts the operation. No Done is issued, and outputs return to their reset values on that edge.
- Reset has priority over Start on the same edge.

## Timing
- Let edge E0 be the edge that accepts Start. Bits 0…WIDTH-1 are processed on edges E1…EWIDTH.
- Done is high for exactly one cycle, between EWIDTH and EWIDTH+1. Diff and Borrow are valid from EWIDTH onward.
- Throughput: one operation per WIDTH+2 cycles. Ready returns high after EWIDTH+1, so the earliest next accept is EWIDTH+2.
- A and B may change freely after E0.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - the Overflow port and logic exist
  - at E0, latch sa=A[WIDTH-1] and sb=B[WIDTH-1]
  - on the final edge, Overflow = (sa != sb) && (d_msb != sa), where d_msb is the last d computed
  - Overflow holds with Diff and resets to 0
- SERIAL_SUB_OVF_EN undefined: no Overflow port, no sign latches. All other behaviour is identical.

## Test plan
All cases use WIDTH=8.
- Reset, then A=8'd5, B=8'd3, Start for 1 cycle at E0 → Busy high E0–E8, Done high for one cycle after E8, Diff=8'h02, Borrow=0.
- A=8'd3, B=8'd5 → Diff=8'hFE, Borrow=1. Back-to-back with A=8'hFF, B=8'hFF issued at the first Ready → Diff=8'h00, Borrow=0, second Done 10 cycles after the first.
- A=8'h00, B=8'h01 → Diff=8'hFF, Borrow=1. Hold Start high throughout → exactly one accept per Ready window, with no extra Done pulses.
- Start with A=8'h10, B=8'h01, then assert Rst at E4 → on that edge Ready=1, Busy=0, Diff=0, Borrow=0, and no Done ever appears. A subsequent A=8'h10, B=8'h01 yields 8'h0F.
- With SERIAL_SUB_OVF_EN: A=8'h80, B=8'h01 → Diff=8'h7F, Borrow=0, Overflow=1. A=8'h7F, B=8'hFF → Diff=8'h80, Overflow=1. A=8'h05, B=8'h03 → Overflow=0.
- Randomised check of 1000 operand pairs against A−B → Diff and Borrow match exactly, and Done latency is 8 edges after E0 in every case.
